pc_sequencer: RTL and testbench

- Owns the program counter and sequences instruction fetch for the CPU datapath.
- Forms the next PC from four sources: PC+4, branch target (sign-extended offset shifted left 2), jump target (upper PC+4 bits plus 26-bit index shifted left 2), and register jump.
- Handshakes with instruction memory and with the decode stage. Holds the PC under stall and supports a sticky halt.

---
 rtl/pc_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Owns the program counter and sequences instruction fetch for the CPU
// datapath. One instruction is in flight at a time: the PC is presented to
// instruction memory in FETCH, the returned word is held for decode in ISSUE,
// and the PC advances only when decode accepts that word.
//
// Handshakes (both sides):
//   imem : imem_req is the request, imem_ready qualifies imem_rdata. A word is
//          captured on the cycle where imem_req & imem_ready are both high.
//   decode: inst_valid is the valid, !stall is the ready. The instruction is
//          accepted on the cycle where inst_valid & !stall. Redirect and halt
//          inputs are sampled only on that cycle.
//
// Ports:
//   clk, clrn                 clock (rising edge), async active-low reset
//   imem_req / imem_addr      fetch request and address (address == pc)
//   imem_ready / imem_rdata   fetched word and its qualifier
//   inst / inst_valid         instruction presented to decode
//   stall                     decode cannot accept this cycle
//   br_taken, br_imm          conditional branch, 16-bit word offset
//   jump, jump_idx            absolute jump, 26-bit word index
//   jr, jr_target             register jump and its byte address
//   halt                      enter HALTED after the accepted instruction
//   pc, pc_plus4              current PC and pc + 4
//   halted                    high while in HALTED
//   align_err                 sticky: a misaligned jr_target was taken
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              clrn,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inst,
    output logic              inst_valid,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [15:0]       br_imm,
    input  logic              jump,
    input  logic [25:0]       jump_idx,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              halted,
    output logic              align_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_ISSUE  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_inst;
    logic              r_inst_valid;
    logic              r_align_err;

    logic              w_imem_req;
    logic              w_load_inst;
    logic              w_accept;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_br_offset;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              w_jr_misaligned;

    // ---------------------------------------------------------------------
    // Next-PC formation. All arithmetic is modulo 2^32 and wraps silently.
    // ---------------------------------------------------------------------
    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_br_offset     = {{14{br_imm[15]}}, br_imm, 2'b00};
    assign w_jr_misaligned = (jr_target[1:0] != 2'b00);

    // Priority: jr > jump > branch > sequential.
    always_comb begin
        w_pc_nxt = w_pc_plus4;
        if (jr) begin
            w_pc_nxt = {jr_target[31:2], 2'b00};
        end else if (jump) begin
            w_pc_nxt = {w_pc_plus4[31:28], jump_idx, 2'b00};
        end else if (br_taken) begin
            w_pc_nxt = w_pc_plus4 + w_br_offset;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and per-state controls
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_imem_req  = 1'b0;
        w_load_inst = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ready) begin
                    w_load_inst = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Everything holds while decode stalls.
                if (r_inst_valid && !stall) begin
                    w_accept    = 1'b1;
                    w_state_nxt = halt ? S_HALTED : S_FETCH;
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_pc         <= RESET_PC;
            r_inst       <= 32'h0;
            r_inst_valid <= 1'b0;
            r_align_err  <= 1'b0;
        end else begin
            if (w_load_inst) begin
                r_inst       <= imem_rdata;
                r_inst_valid <= 1'b1;
            end else if (w_accept) begin
                r_inst_valid <= 1'b0;
            end

            if (w_accept) begin
                r_pc <= w_pc_nxt;
                // Only a taken jr can raise the flag; lower-priority sources
                // never look at jr_target.
                if (jr && w_jr_misaligned) begin
                    r_align_err <= 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign imem_req   = w_imem_req;
    assign imem_addr  = r_pc;
    assign inst       = r_inst;
    assign inst_valid = r_inst_valid;
    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign halted     = (r_state == S_HALTED);
    assign align_err  = r_align_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed bench for pc_sequencer. Instruction memory is a pure function of
// the address (addr ^ MEM_KEY). The bench keeps its own PC model; when a
// fetch is granted the word expected for that PC is pushed onto exp_q and
// popped when the DUT presents inst to decode.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] MEM_KEY  = 32'h1357_9BDF;

    logic        clk;
    logic        clrn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_imm;
    logic        jump;
    logic [25:0] jump_idx;
    logic        jr;
    logic [31:0] jr_target;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        align_err;

    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    logic        exp_align;
    int          n_assert;
    int          n_fail;

    pc_sequencer #(
        .RESET_PC (RESET_PC),
        .ADDR_W   (32)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_imm     (br_imm),
        .jump       (jump),
        .jump_idx   (jump_idx),
        .jr         (jr),
        .jr_target  (jr_target),
        .halt       (halt),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .halted     (halted),
        .align_err  (align_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents
    assign imem_rdata = imem_addr ^ MEM_KEY;

    // ---------------------------------------------------------------------
    // Checkers
    // ---------------------------------------------------------------------
    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference next-PC model
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic br,
                                               input logic [15:0] imm, input logic jmp,
                                               input logic [25:0] idx, input logic j_r,
                                               input logic [31:0] jrt);
        logic [31:0] p4;
        logic [31:0] off;
        p4  = p + 32'd4;
        off = {{14{imm[15]}}, imm, 2'b00};
        if (j_r)      return {jrt[31:2], 2'b00};
        else if (jmp) return {p4[31:28], idx, 2'b00};
        else if (br)  return p4 + off;
        else          return p4;
    endfunction

    task automatic clear_ctrl();
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_imm    = 16'h0;
        jump      = 1'b0;
        jump_idx  = 26'h0;
        jr        = 1'b0;
        jr_target = 32'h0;
        halt      = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // One instruction: entered at a negedge with the DUT in FETCH, leaves at
    // the negedge after the accept.
    // ---------------------------------------------------------------------
    task automatic run_instr(input int ready_wait, input int stall_cyc,
                             input logic br, input logic [15:0] imm,
                             input logic jmp, input logic [25:0] idx,
                             input logic j_r, input logic [31:0] jrt,
                             input logic hlt);
        logic [31:0] nxt;
        logic [31:0] exp_inst;

        for (int w = 0; w < ready_wait; w++) begin
            imem_ready = 1'b0;
            check1 ("req_wait",  imem_req, 1'b1);
            check32("addr_wait", imem_addr, exp_pc);
            @(negedge clk);
        end

        check1 ("req",      imem_req, 1'b1);
        check32("addr",     imem_addr, exp_pc);
        check32("pc_plus4", pc_plus4, exp_pc + 32'd4);
        exp_q.push_back(exp_pc ^ MEM_KEY);
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;

        exp_inst = exp_q.pop_front();
        check1 ("issue_valid", inst_valid, 1'b1);
        check1 ("issue_req",   imem_req, 1'b0);
        check32("issue_inst",  inst, exp_inst);

        // Stalled cycles: redirect inputs wiggle but must be ignored.
        for (int s = 0; s < stall_cyc; s++) begin
            stall     = 1'b1;
            br_taken  = s[0];
            br_imm    = 16'($urandom_range(0, 65535));
            jump      = 1'($urandom_range(0, 1));
            jump_idx  = 26'($urandom_range(0, 32'h03FF_FFFF));
            halt      = 1'($urandom_range(0, 1));
            @(negedge clk);
            check32("stall_inst",  inst, exp_inst);
            check32("stall_pc",    pc, exp_pc);
            check1 ("stall_valid", inst_valid, 1'b1);
            check1 ("stall_req",   imem_req, 1'b0);
        end

        stall     = 1'b0;
        br_taken  = br;
        br_imm    = imm;
        jump      = jmp;
        jump_idx  = idx;
        jr        = j_r;
        jr_target = jrt;
        halt      = hlt;
        nxt = model_next(exp_pc, br, imm, jmp, idx, j_r, jrt);
        if (j_r && (jrt[1:0] != 2'b00)) exp_align = 1'b1;
        @(negedge clk);
        clear_ctrl();

        exp_pc = nxt;
        check32("acc_pc",    pc, exp_pc);
        check1 ("acc_valid", inst_valid, 1'b0);
        check1 ("acc_req",   imem_req, !hlt);
        check1 ("acc_halt",  halted, hlt);
        check1 ("acc_align", align_err, exp_align);
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_pc"},    pc, RESET_PC);
        check32({tag, "_inst"},  inst, 32'h0);
        check1 ({tag, "_valid"}, inst_valid, 1'b0);
        check1 ({tag, "_req"},   imem_req, 1'b0);
        check1 ({tag, "_halt"},  halted, 1'b0);
        check1 ({tag, "_align"}, align_err, 1'b0);
    endtask

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin
        n_assert   = 0;
        n_fail     = 0;
        exp_align  = 1'b0;
        clrn       = 1'b0;
        imem_ready = 1'b0;
        clear_ctrl();

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Release reset: one IDLE cycle, then FETCH at RESET_PC.
        clrn = 1'b1;
        check1("idle_req", imem_req, 1'b0);
        @(negedge clk);
        exp_pc = RESET_PC;

        // Sequential 0,4,8,C
        for (int i = 0; i < 4; i++) begin
            run_instr(0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
        end

        // Reach 0x100, branch backwards to 0xFC
        run_instr(0, 0, 1'b0, 16'h0,    1'b0, 26'h0, 1'b1, 32'h0000_0100, 1'b0);
        run_instr(0, 0, 1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0,         1'b0);
        check32("br_back", exp_pc, 32'h0000_00FC);
        // Back to 0x100, branch forward to 0x110
        run_instr(0, 0, 1'b0, 16'h0,    1'b0, 26'h0, 1'b1, 32'h0000_0100, 1'b0);
        run_instr(0, 0, 1'b1, 16'h0003, 1'b0, 26'h0, 1'b0, 32'h0,         1'b0);

        // Jump from 0x4000_0010 with a simultaneous branch: jump wins
        run_instr(0, 0, 1'b0, 16'h0,    1'b0, 26'h0,       1'b1, 32'h4000_0010, 1'b0);
        run_instr(0, 0, 1'b1, 16'h0040, 1'b1, 26'h0000040, 1'b0, 32'h0,         1'b0);

        // Misaligned jr beats jump and branch; align_err turns sticky
        run_instr(0, 0, 1'b1, 16'h0040, 1'b1, 26'h0000040, 1'b1, 32'h0000_2003, 1'b0);

        // imem_ready low for 3 cycles
        run_instr(3, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);

        // Stall 4 cycles, branch taken only on the cycle stall falls
        run_instr(0, 4, 1'b1, 16'h0010, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);

        // Sequential wrap at the top of the address space
        run_instr(0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        run_instr(0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0,         1'b0);

        // Halt combined with a jump
        run_instr(0, 0, 1'b0, 16'h0, 1'b1, 26'h0ABCDEF, 1'b0, 32'h0, 1'b1);
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1 ("halt_req",   imem_req, 1'b0);
            check1 ("halt_flag",  halted, 1'b1);
            check1 ("halt_valid", inst_valid, 1'b0);
            check32("halt_pc",    pc, exp_pc);
        end
        imem_ready = 1'b0;

        // Reset out of HALTED, then abort a fetch with an async reset pulse
        clrn = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset2");
        clrn = 1'b1;
        @(negedge clk);
        check1 ("fetch_req",  imem_req, 1'b1);
        check32("fetch_addr", imem_addr, RESET_PC);
        // Load one instruction so reset has something to clear.
        exp_pc = RESET_PC;
        run_instr(0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_0803, 1'b0);
        #2;
        clrn = 1'b0;
        #1;
        check_reset_outputs("async");
        @(negedge clk);
        clrn = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
